// File: rtl/stream_sel_mux.sv
// stream_sel_mux: selects one of NCH valid/ready input channels into a single
// registered output slot. The channel is picked either by the sel input
// (fixed mode) or by a rotating round-robin pointer (rr_en=1).
//
// Handshake: a word moves across an interface in any cycle where its valid
// and ready are both 1. The output side is a single register slot. It loads
// when it is empty or is being drained in the same cycle (load_ok) and a
// channel is granted. in_ready is a combinational one-hot strobe naming the
// channel whose word is taken this cycle. valid never waits on ready.
module stream_sel_mux #(
    parameter int WIDTH = 2,
    parameter int NCH   = 2,
    parameter int SELW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 rr_en,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Output slot and round-robin pointer state.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    // Grant decision for the current cycle.
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SELW-1:0]  cand;
    logic             load_ok;
    logic             do_load;

    // Channel index arithmetic modulo NCH. base is always below NCH and off is
    // at most NCH-1, so one conditional subtraction is enough.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return s[SELW-1:0];
    endfunction

    assign load_ok = !out_valid_q || out_ready;
    assign do_load = load_ok && grant_vld;

    // Pick the granted channel: sel in fixed mode, first valid from ptr in rr mode.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (rr_en) begin
            for (int i = 0; i < NCH; i++) begin
                cand = wrap_add(ptr_q, i);
                if (!grant_vld && in_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end else begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int k = 0; k < NCH; k++) begin
                if (sel == SELW'(k) && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(k);
                end
            end
        end
    end

    // Route the granted channel's data word.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_idx == SELW'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot accept strobe; held low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && do_load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next state of the output slot and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (do_load) begin
            // Covers both an empty slot and a same-cycle drain-and-refill.
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            if (rr_en) begin
                ptr_d = wrap_add(grant_idx, 1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held word and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Bench for stream_sel_mux: a driver issues one input pattern per cycle and
// pushes predicted output words into exp_q. An independent monitor compares
// every word the DUT presents against the queue head.
module tb_stream_sel_mux;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 rr_en;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    stream_sel_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rr_en    (rr_en),
        .sel      (sel),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected output words {channel, data}, oldest first.
    logic [SELW+WIDTH-1:0] exp_q[$];

    // Reference state: is the output slot full, and where round-robin starts.
    logic m_valid;
    int   m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: -1 means no channel is granted.
    function automatic int model_grant(input logic rr, input int s,
                                       input logic [NCH-1:0] iv, input int p);
        if (!rr) begin
            if (s < NCH && iv[s]) return s;
            return -1;
        end
        for (int i = 0; i < NCH; i++) begin
            int k;
            k = (p + i) % NCH;
            if (iv[k]) return k;
        end
        return -1;
    endfunction

    // Driver: apply one cycle of stimulus, predict, and advance the reference.
    task automatic step(input logic rr, input logic [SELW-1:0] s, input logic [NCH-1:0] iv,
                        input logic ordy, input logic [NCH*WIDTH-1:0] d);
        int             g;
        logic           lok;
        logic [NCH-1:0] exp_rdy;
        logic           nv;
        int             np;
        @(negedge clk);
        rr_en     = rr;
        sel       = s;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = d;
        #1;
        lok     = !m_valid || ordy;
        g       = model_grant(rr, int'(s), iv, m_ptr);
        exp_rdy = '0;
        nv      = m_valid && !ordy;
        np      = m_ptr;
        if (lok && g >= 0) begin
            exp_rdy[g] = 1'b1;
            nv         = 1'b1;
            if (rr) np = (g + 1) % NCH;
            exp_q.push_back({SELW'(g), d[g*WIDTH +: WIDTH]});
        end
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        m_valid = nv;
        m_ptr   = np;
    endtask

    function automatic logic [NCH*WIDTH-1:0] rand_data();
        logic [NCH*WIDTH-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
        return d;
    endfunction

    // Asynchronous reset pulse, asserted between clock edges; called right
    // after a step returns at a rising edge.
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_ch", out_ch, '0);
        chk("rst_in_ready", in_ready, '0);
        m_valid = 1'b0;
        m_ptr   = 0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_hold_in_ready", in_ready, '0);
        in_valid  = '0;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: checks each presented word against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("out_valid", out_valid, m_valid);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_word actual=%0h required=none", {out_ch, out_data});
                end else begin
                    chk("out_word", {out_ch, out_data}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus and directed scenarios.
    initial begin
        logic [NCH*WIDTH-1:0] d;
        int                   seq[5];
        seq = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        rr_en     = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_ptr     = 0;
        #1;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_out_data", out_data, '0);
        chk("init_out_ch", out_ch, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fixed mode, sel=2, only ch2 valid with A5.
        d = rand_data();
        d[2*WIDTH +: WIDTH] = 8'hA5;
        step(1'b0, 2'd2, 4'b0100, 1'b1, d);
        #1;
        chk("fixed_valid", out_valid, 1'b1);
        chk("fixed_data", out_data, 8'hA5);
        chk("fixed_ch", out_ch, 2'd2);

        // Fixed mode, sel=1 not valid: no grant, word drains.
        step(1'b0, 2'd1, 4'b1101, 1'b1, rand_data());
        #1;
        chk("fixed_nogrant_valid", out_valid, 1'b0);

        // Round-robin from reset with all channels valid.
        reset_mid();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b1, rand_data());
            #1;
            chk("rr_seq_ch", out_ch, seq[i]);
        end

        // Pointer now 1 with channels 0 and 3 valid: ch3 then ch0.
        step(1'b1, 2'd0, 4'b1001, 1'b1, rand_data());
        #1;
        chk("rr_wrap_ch3", out_ch, 2'd3);
        step(1'b1, 2'd0, 4'b1001, 1'b1, rand_data());
        #1;
        chk("rr_wrap_ch0", out_ch, 2'd0);

        // Backpressure: hold 3C for three cycles, then drain and refill together.
        d = rand_data();
        d[7:0] = 8'h3C;
        step(1'b0, 2'd0, 4'b0001, 1'b1, d);
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'b1111, 1'b0, rand_data());
            #1;
            chk("bp_hold_data", out_data, 8'h3C);
        end
        d = rand_data();
        d[7:0] = 8'h77;
        step(1'b0, 2'd0, 4'b0001, 1'b1, d);
        #1;
        chk("bp_refill_valid", out_valid, 1'b1);
        chk("bp_refill_data", out_data, 8'h77);

        // Reset while a word is held, then round-robin restarts at ch0.
        step(1'b1, 2'd0, 4'b1110, 1'b0, rand_data());
        reset_mid();
        step(1'b1, 2'd0, 4'b1111, 1'b1, rand_data());
        #1;
        chk("post_reset_rr_ch", out_ch, 2'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), rand_data());
        end

        // Drain.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 4'b0000, 1'b1, '0);
        end
        @(negedge clk);
        #3;
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
